// File: rtl/jt12_acc_pkg.sv
// Shared types and helpers for the FM channel accumulator/mixer.
package jt12_acc_pkg;

  typedef enum logic [2:0] {
    ALG_0 = 3'd0,
    ALG_1 = 3'd1,
    ALG_2 = 3'd2,
    ALG_3 = 3'd3,
    ALG_4 = 3'd4,
    ALG_5 = 3'd5,
    ALG_6 = 3'd6,
    ALG_7 = 3'd7
  } alg_e;

  localparam int unsigned PAN_L = 1;
  localparam int unsigned PAN_R = 0;

  // Clamp a signed value to the range of a signed w-bit number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x,
                                             input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/jt12_acc_mix_sh_rst.sv
// Width/depth-parametrised shift register with async active-low reset.
module jt12_sh_rst
  import jt12_acc_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/jt12_acc_mix.sv
// FM channel accumulator and stereo mixer with pan, mute, saturation and clip flag.
// Optional clip_cnt output enabled by defining JT12_ACC_CLIPCNT_EN.
module jt12_acc_mix
  import jt12_acc_pkg::*;
#(
  parameter int unsigned CH   = 6,
  parameter int unsigned OPW  = 9,
  parameter int unsigned ACCW = 11,
  parameter int unsigned OUTW = 14,
  parameter int unsigned PCMW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [OPW-1:0]  op_result,
  input  logic [1:0]             rl,
  input  logic                   s1_enters,
  input  logic                   s3_enters,
  input  logic                   s2_enters,
  input  logic                   s4_enters,
  input  logic [2:0]             alg,
  input  logic                   pcm_en,
  input  logic [PCMW-1:0]        pcm,
  input  logic [CH-1:0]          ch_mute,
  output logic signed [OUTW-1:0] left,
  output logic signed [OUTW-1:0] right,
  output logic                   sample,
  output logic                   clip
`ifdef JT12_ACC_CLIPCNT_EN
  ,
  output logic [7:0]             clip_cnt
`endif
);

  localparam int unsigned CHW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned MIXW  = ACCW + $clog2(CH) + 1;
  localparam int unsigned SHIFT = OUTW - ACCW - 1;

  logic                   sum_en_c;
  logic signed [ACCW-1:0] op_ext_c, addend_c, tail_c, next_c;
  logic [ACCW-1:0]        tail_raw;
  logic                   first_s3_c, first_s2_c, mute_c;
  logic [CHW-1:0]         ch_cur_c;
  logic signed [MIXW-1:0] tail_mix_c, contrib_l_c, contrib_r_c;
  logic signed [31:0]     sat_l_c, sat_r_c;
  logic                   clip_l_c, clip_r_c;

  logic                   s3_prev_q, s2_prev_q;
  logic [1:0]             warm_q, warm_d;
  logic [CHW-1:0]         ch_idx_q, ch_idx_d;
  logic signed [MIXW-1:0] mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic signed [OUTW-1:0] left_q, left_d, right_q, right_d;
  logic                   sample_q, sample_d, clip_q, clip_d;

  // Operator enable for the current slot from the algorithm's carrier set.
  always_comb begin
    sum_en_c = 1'b0;
    case (alg_e'(alg))
      ALG_0, ALG_1, ALG_2, ALG_3: sum_en_c = s4_enters;
      ALG_4:                      sum_en_c = s2_enters | s4_enters;
      ALG_5, ALG_6:               sum_en_c = ~s1_enters;
      default:                    sum_en_c = 1'b1;
    endcase
  end

  assign op_ext_c = ACCW'(op_result);
  assign addend_c = sum_en_c ? op_ext_c : '0;
  assign tail_c   = $signed(tail_raw);

  // S3 starts a fresh partial sum; every other group adds to the channel's running sum.
  always_comb begin
    next_c = addend_c + tail_c;
    if (s3_enters) next_c = pcm_en ? $signed(ACCW'(pcm)) : addend_c;
  end

  jt12_sh_rst #(
    .W      (ACCW),
    .STAGES (CH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (next_c),
    .q_o   (tail_raw)
  );

  assign first_s3_c = s3_enters & ~s3_prev_q;
  assign first_s2_c = s2_enters & ~s2_prev_q;
  assign ch_cur_c   = first_s3_c ? '0 : ch_idx_q;
  assign ch_idx_d   = (ch_cur_c == CHW'(CH - 1)) ? '0 : ch_cur_c + CHW'(1);
  assign warm_d     = (first_s3_c && warm_q != 2'd2) ? warm_q + 2'd1 : warm_q;

  assign mute_c      = ch_mute[ch_cur_c];
  assign tail_mix_c  = MIXW'(tail_c);
  assign contrib_l_c = (!mute_c && rl[PAN_L]) ? tail_mix_c : '0;
  assign contrib_r_c = (!mute_c && rl[PAN_R]) ? tail_mix_c : '0;

  always_comb begin
    mix_l_d = mix_l_q;
    mix_r_d = mix_r_q;
    if (s3_enters) begin
      mix_l_d = first_s3_c ? contrib_l_c : mix_l_q + contrib_l_c;
      mix_r_d = first_s3_c ? contrib_r_c : mix_r_q + contrib_r_c;
    end
  end

  assign sat_l_c  = sat(32'(mix_l_q), ACCW + 1);
  assign sat_r_c  = sat(32'(mix_r_q), ACCW + 1);
  assign clip_l_c = sat_l_c != 32'(mix_l_q);
  assign clip_r_c = sat_r_c != 32'(mix_r_q);

  // Publish only once the mixed sums come from a frame fully accumulated since reset.
  always_comb begin
    left_d   = left_q;
    right_d  = right_q;
    clip_d   = clip_q;
    sample_d = 1'b0;
    if (first_s2_c && warm_q == 2'd2) begin
      left_d   = OUTW'(sat_l_c <<< SHIFT);
      right_d  = OUTW'(sat_r_c <<< SHIFT);
      clip_d   = clip_l_c | clip_r_c;
      sample_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_prev_q <= 1'b1;
      s2_prev_q <= 1'b1;
      warm_q    <= '0;
      ch_idx_q  <= '0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      sample_q  <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      s3_prev_q <= s3_enters;
      s2_prev_q <= s2_enters;
      warm_q    <= warm_d;
      ch_idx_q  <= ch_idx_d;
      mix_l_q   <= mix_l_d;
      mix_r_q   <= mix_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      sample_q  <= sample_d;
      clip_q    <= clip_d;
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q;
  assign clip   = clip_q;

`ifdef JT12_ACC_CLIPCNT_EN
  logic [7:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (sample_d) begin
      if (clip_d && clip_cnt_q != 8'd255) clip_cnt_d = clip_cnt_q + 8'd1;
      else if (!clip_d && clip_cnt_q == 8'd255) clip_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) clip_cnt_q <= '0;
    else      clip_cnt_q <= clip_cnt_d;
  end

  assign clip_cnt = clip_cnt_q;
`endif

`ifndef SYNTHESIS
  strobe_onehot_a: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({s1_enters, s2_enters, s3_enters, s4_enters}))
    else $error("simultaneous slot group strobes");
`endif

endmodule
